// File: rtl/itrx_aib_phy_clk_mux_seq_pkg.sv
// Shared state encoding and constants for the AIB PHY clock-mux switch sequencer.
// Types only; carries no latency and no flow control.
package itrx_aib_phy_clk_mux_seq_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GATE_OFF = 3'd1,
    SWITCH   = 3'd2,
    GATE_ON  = 3'd3,
    DONE     = 3'd4
  } state_t;

  // A zero settle request still spends one cycle in each phase.
  localparam int SETTLE_MIN = 1;

endpackage

// File: rtl/itrx_aib_phy_clk_mux_seq_cnt.sv
// Loadable down-counter that saturates at zero; load wins over decrement.
// Zero flag reflects the registered count; no flow control.
module itrx_aib_phy_clk_mux_seq_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_zero;

  assign w_zero = (r_cnt == '0);
  assign o_zero = w_zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && !w_zero) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/itrx_aib_phy_clk_mux_seq.sv
// Glitch-free clock-switch sequencer: gate off old source, flip select, gate on new, N cycles each.
// All outputs registered; accept-to-ready is 3N+2 cycles; requests while busy are dropped.
module itrx_aib_phy_clk_mux_seq
  import itrx_aib_phy_clk_mux_seq_pkg::*;
#(
  parameter logic RESET_SEL = 1'b0,
  parameter int   CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_vld,
  input  logic             req_sel,
  output logic             req_rdy,
  input  logic [CNT_W-1:0] settle_cyc,
  output logic             msel,
  output logic             gate_en0,
  output logic             gate_en1,
  output logic             done,
  output logic             busy
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_msel;
  logic             r_gate_en0;
  logic             r_gate_en1;
  logic             r_done;
  logic             r_busy;
  logic             r_rdy;
  logic [CNT_W-1:0] r_nm1;

  logic             w_msel_nxt;
  logic             w_gate_en0_nxt;
  logic             w_gate_en1_nxt;
  logic             w_accept;
  logic [CNT_W-1:0] w_settle_nm1;
  logic             w_cnt_load;
  logic [CNT_W-1:0] w_cnt_load_val;
  logic             w_cnt_dec;
  logic             w_cnt_zero;

  assign w_accept     = req_vld && r_rdy;
  assign w_settle_nm1 = (settle_cyc < CNT_W'(SETTLE_MIN)) ? '0
                                                          : settle_cyc - CNT_W'(SETTLE_MIN);

  itrx_aib_phy_clk_mux_seq_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_load_val),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_cnt_zero)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_msel_nxt     = r_msel;
    w_gate_en0_nxt = r_gate_en0;
    w_gate_en1_nxt = r_gate_en1;
    w_cnt_load     = 1'b0;
    w_cnt_load_val = r_nm1;
    w_cnt_dec      = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (req_sel == r_msel) begin
            w_state_nxt = DONE;
          end else begin
            w_state_nxt    = GATE_OFF;
            w_cnt_load     = 1'b1;
            w_cnt_load_val = w_settle_nm1;
            if (r_msel) begin
              w_gate_en1_nxt = 1'b0;
            end else begin
              w_gate_en0_nxt = 1'b0;
            end
          end
        end
      end

      GATE_OFF: begin
        if (w_cnt_zero) begin
          w_state_nxt = SWITCH;
          w_msel_nxt  = ~r_msel;
          w_cnt_load  = 1'b1;
        end else begin
          w_cnt_dec = 1'b1;
        end
      end

      SWITCH: begin
        // Both enables are held low here so the select flip happens with no clock passing.
        w_gate_en0_nxt = 1'b0;
        w_gate_en1_nxt = 1'b0;
        if (w_cnt_zero) begin
          w_state_nxt = GATE_ON;
          w_cnt_load  = 1'b1;
          if (r_msel) begin
            w_gate_en1_nxt = 1'b1;
          end else begin
            w_gate_en0_nxt = 1'b1;
          end
        end else begin
          w_cnt_dec = 1'b1;
        end
      end

      GATE_ON: begin
        if (w_cnt_zero) begin
          w_state_nxt = DONE;
        end else begin
          w_cnt_dec = 1'b1;
        end
      end

      DONE: begin
        w_state_nxt = IDLE;
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_msel     <= RESET_SEL;
      r_gate_en0 <= ~RESET_SEL;
      r_gate_en1 <= RESET_SEL;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_rdy      <= 1'b1;
      r_nm1      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_msel     <= w_msel_nxt;
      r_gate_en0 <= w_gate_en0_nxt;
      r_gate_en1 <= w_gate_en1_nxt;
      r_done     <= (w_state_nxt == DONE);
      r_busy     <= (w_state_nxt != IDLE);
      r_rdy      <= (w_state_nxt == IDLE);
      if (w_accept) begin
        r_nm1 <= w_settle_nm1;
      end
    end
  end

  assign msel     = r_msel;
  assign gate_en0 = r_gate_en0;
  assign gate_en1 = r_gate_en1;
  assign done     = r_done;
  assign busy     = r_busy;
  assign req_rdy  = r_rdy;

endmodule

// File: tb/tb_itrx_aib_phy_clk_mux_seq.sv
// Directed bench for the clock-mux switch sequencer: vector table plus multi-cycle sequences.
// Output vectors are packed as {msel, gate_en0, gate_en1, done, busy, req_rdy}.
module tb_itrx_aib_phy_clk_mux_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_vld;
  logic       req_sel;
  logic [7:0] settle_cyc;

  logic rdy0, msel0, g00, g10, done0, busy0;
  logic rdy1, msel1, g01, g11, done1, busy1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  itrx_aib_phy_clk_mux_seq #(.RESET_SEL(1'b0), .CNT_W(8)) u_dut0 (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_sel(req_sel), .req_rdy(rdy0),
    .settle_cyc(settle_cyc), .msel(msel0), .gate_en0(g00), .gate_en1(g10),
    .done(done0), .busy(busy0)
  );

  itrx_aib_phy_clk_mux_seq #(.RESET_SEL(1'b1), .CNT_W(8)) u_dut1 (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_sel(req_sel), .req_rdy(rdy1),
    .settle_cyc(settle_cyc), .msel(msel1), .gate_en0(g01), .gate_en1(g11),
    .done(done1), .busy(busy1)
  );

  logic [5:0] out0, out1;
  assign out0 = {msel0, g00, g10, done0, busy0, rdy0};
  assign out1 = {msel1, g01, g11, done1, busy1, rdy1};

  localparam logic [5:0] RST0 = 6'b010001;
  localparam logic [5:0] RST1 = 6'b101001;

  task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (msel,en0,en1,done,busy,rdy)", name, act, exp);
    end
  endtask

  // Invariant monitor on dut0; cycles whose edge saw reset are skipped.
  bit   mon_en = 1'b0;
  logic last_rst = 1'b1;
  logic p_msel, p_g0, p_g1;

  always @(posedge clk) last_rst = rst;

  always @(negedge clk) begin
    if (mon_en && !last_rst) begin
      checks++;
      if (g00 && g10) begin
        errors++;
        $display("FAIL both_enables: got en0=%b en1=%b expected not both 1", g00, g10);
      end
      if (msel0 !== p_msel) begin
        checks++;
        if ((p_msel ? p_g1 : p_g0) !== 1'b0) begin
          errors++;
          $display("FAIL msel_while_enabled: msel %b->%b with old enable=%b expected 0",
                   p_msel, msel0, p_msel ? p_g1 : p_g0);
        end
      end
    end
    p_msel = msel0;
    p_g0   = g00;
    p_g1   = g10;
  end

  task automatic do_reset(input string tag);
    rst = 1'b1; req_vld = 1'b0;
    @(posedge clk); @(negedge clk);
    chk({tag, "_rst_sel0"}, out0, RST0);
    chk({tag, "_rst_sel1"}, out1, RST1);
    rst = 1'b0;
  endtask

  // Accept a switch to new_sel, then check every cycle up to the first ready cycle.
  task automatic run_switch(input int n_raw, input logic new_sel, input bit disturb);
    int n;
    logic [5:0] e;
    logic gnew;
    n = (n_raw == 0) ? 1 : n_raw;
    req_vld = 1'b1; req_sel = new_sel; settle_cyc = 8'(n_raw);
    @(posedge clk); @(negedge clk);
    for (int k = 1; k <= 3*n + 2; k++) begin
      gnew = (k >= 1 + 2*n);
      e = {(k >= 1 + n) ? new_sel : ~new_sel,
           new_sel ? 1'b0 : gnew,
           new_sel ? gnew : 1'b0,
           (k == 1 + 3*n),
           (k <= 1 + 3*n),
           (k == 3*n + 2)};
      chk($sformatf("sw_n%0d_sel%0d_k%0d", n_raw, new_sel, k), out0, e);
      if (disturb && k < 3*n + 2) begin
        req_vld    = (k % 2) == 1;
        req_sel    = (k % 4) >= 2;
        settle_cyc = 8'($urandom_range(0, 255));
      end else begin
        req_vld = 1'b0;
      end
      if (k < 3*n + 2) begin
        @(posedge clk); @(negedge clk);
      end
    end
  endtask

  typedef struct {
    logic       rst;
    logic       vld;
    logic       sel;
    logic [7:0] settle;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[18];

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'd0, 6'b010001};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 8'd0, 6'b000010};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 8'd0, 6'b100010};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 8'd0, 6'b101010};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 8'd0, 6'b101110};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 8'd0, 6'b101001};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 8'd0, 6'b101110};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 8'd0, 6'b101001};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 8'd1, 6'b100010};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 8'd0, 6'b000010};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 8'd0, 6'b010010};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 8'd0, 6'b010110};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 8'd0, 6'b010001};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 8'd0, 6'b000010};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 8'd0, 6'b100010};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 8'd0, 6'b101010};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 8'd0, 6'b101110};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 8'd0, 6'b101001};

    rst = 1'b1; req_vld = 1'b0; req_sel = 1'b0; settle_cyc = '0;
    @(negedge clk);
    do_reset("init");
    mon_en = 1'b1;

    for (int i = 0; i < 18; i++) begin
      rst = vecs[i].rst; req_vld = vecs[i].vld; req_sel = vecs[i].sel;
      settle_cyc = vecs[i].settle;
      @(posedge clk); @(negedge clk);
      chk($sformatf("vec%0d", i), out0, vecs[i].exp);
    end
    req_vld = 1'b0;

    // settle 4: en0 off at T+1, msel at T+5, en1 at T+9, done T+13, ready T+14
    do_reset("pre_n4");
    run_switch(4, 1'b1, 1'b0);

    // busy-time requests and settle changes must not disturb the captured N
    run_switch(4, 1'b0, 1'b1);

    // reset while sitting in SWITCH
    req_vld = 1'b1; req_sel = 1'b1; settle_cyc = 8'd3;
    @(posedge clk); @(negedge clk);
    req_vld = 1'b0;
    for (int k = 1; k < 5; k++) begin
      @(posedge clk); @(negedge clk);
    end
    chk("mid_switch", out0, 6'b100010);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("mid_rst_sel0", out0, RST0);
    chk("mid_rst_sel1", out1, RST1);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); @(negedge clk);
      chk($sformatf("post_rst_idle%0d", k), out0, RST0);
    end

    // maximum settle: no counter wrap, 3*255+2 cycles to ready
    run_switch(255, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
